// File: rtl/time_count_pkg.sv
// Shared constants and helpers for the four-digit decimal time counter.
package time_count_pkg;

  localparam int CYCLES_PER_TICK_DEFAULT = 50_000_000;
  localparam int PRESCALE_W              = 26;
  localparam int DIGIT_W                 = 4;
  localparam int NUM_DIGITS              = 4;
  localparam int SEG_W                   = 7;

  typedef logic [DIGIT_W-1:0]    digit_t;
  typedef logic [SEG_W-1:0]      seg_t;
  typedef logic [PRESCALE_W-1:0] prescale_t;

  // Active-low segment patterns, bit0=a ... bit6=g.
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic   carry;
    digit_t digit;
  } bcd_step_t;

  // Values of 9 and above roll to 0 so a digit can never leave 0..9.
  function automatic bcd_step_t bcd_inc(input digit_t d, input logic cin);
    bcd_step_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (cin) begin
      if (d >= digit_t'(9)) begin
        r.digit = '0;
        r.carry = 1'b1;
      end else begin
        r.digit = d + digit_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/time_count_hex_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank the display.
module hex_decoder
  import time_count_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_count.sv
// Four-digit decimal counter advanced once every CYCLES_PER_TICK enabled clocks,
// shown on four active-low 7-segment displays.
module time_count
  import time_count_pkg::*;
#(
  parameter int CYCLES_PER_TICK = CYCLES_PER_TICK_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam prescale_t TICK_LAST = prescale_t'(CYCLES_PER_TICK - 1);

  prescale_t                          prescaler_q, prescaler_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_q, digit_d;
  logic                               tick;
  logic [NUM_DIGITS:0]                carry;
  bcd_step_t                          step [NUM_DIGITS];

  assign tick = SW && (prescaler_q == TICK_LAST);

  always_comb begin
    prescaler_d = prescaler_q;
    if (SW) begin
      prescaler_d = tick ? '0 : prescaler_q + prescale_t'(1);
    end
  end

  // Ripple the tick through the digits; each carry lands on the same edge.
  always_comb begin
    carry    = '0;
    carry[0] = tick;
    digit_d  = digit_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step[i]    = bcd_inc(digit_q[i], carry[i]);
      digit_d[i] = step[i].digit;
      carry[i+1] = step[i].carry;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prescaler_q <= '0;
      digit_q     <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      digit_q     <= digit_d;
    end
  end

  hex_decoder u_hex0 (.digit(digit_q[0]), .seg(HEX0));
  hex_decoder u_hex1 (.digit(digit_q[1]), .seg(HEX1));
  hex_decoder u_hex2 (.digit(digit_q[2]), .seg(HEX2));
  hex_decoder u_hex3 (.digit(digit_q[3]), .seg(HEX3));

endmodule

// File: tb/tb_time_count.sv
// Directed self-checking bench for time_count with a 4-cycle tick.
module tb_time_count;

  logic       clock;
  logic       reset;
  logic       sw;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] decIn;
  logic [6:0] decOut;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  time_count #(.CYCLES_PER_TICK(4)) dut (
    .CLOCK_50(clock),
    .reset   (reset),
    .SW      (sw),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2),
    .HEX3    (hex3)
  );

  hex_decoder u_dec (.digit(decIn), .seg(decOut));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [6:0] observed,
                             input logic [6:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input logic rst, input logic en, input int n);
    reset = rst;
    sw    = en;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                          input logic [6:0] e1, input logic [6:0] e0);
    checkOutput({tag, ".hex3"}, hex3, e3);
    checkOutput({tag, ".hex2"}, hex2, e2);
    checkOutput({tag, ".hex1"}, hex1, e1);
    checkOutput({tag, ".hex0"}, hex0, e0);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 1'b0;
    decIn = 4'd0;

    applyStimulus(1'b1, 1'b0, 3);
    checkAll("reset", 7'h40, 7'h40, 7'h40, 7'h40);

    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("first_tick_edge3", hex0, 7'h40);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("first_tick_edge4", hex0, 7'h79);
    applyStimulus(1'b0, 1'b1, 36);
    checkOutput("edge40_hex1", hex1, 7'h79);
    checkOutput("edge40_hex0", hex0, 7'h40);

    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("pause_hold", hex0, 7'h40);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("resume_edge1", hex0, 7'h40);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("resume_edge2", hex0, 7'h79);

    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1);
    checkAll("reset_on_tick", 7'h40, 7'h40, 7'h40, 7'h40);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("after_reset_edge3", hex0, 7'h40);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("after_reset_edge4", hex0, 7'h79);

    applyStimulus(1'b1, 1'b0, 1);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("sweep%0d", k), hex0, segTable[k]);
      applyStimulus(1'b0, 1'b1, 4);
    end

    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 999 * 4);
    checkAll("count0999", 7'h40, 7'h10, 7'h10, 7'h10);
    applyStimulus(1'b0, 1'b1, 4);
    checkAll("count1000", 7'h79, 7'h40, 7'h40, 7'h40);
    applyStimulus(1'b0, 1'b1, 8999 * 4);
    checkAll("count9999", 7'h10, 7'h10, 7'h10, 7'h10);
    applyStimulus(1'b0, 1'b1, 4);
    checkAll("wrap0000", 7'h40, 7'h40, 7'h40, 7'h40);

    for (int v = 0; v < 16; v++) begin
      decIn = 4'(v);
      #1;
      checkOutput($sformatf("dec%0d", v), decOut, (v < 10) ? segTable[v] : 7'h7F);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
